// File: rtl/a0_uart_tx_if.sv
// a0_uart_tx_if -- signal bundle between the register-file tap and the UART word transmitter.
//   a0_in      : live value of register x10 (a0), driven by the producer side
//   tx         : UART 8N1 serial line (idle high)
//   busy       : high while a 32-bit word is being shifted out
//   words_sent : count of completed word transmissions (wraps at 2^16)
// master modport = producer / observer, slave modport = transmitter.
interface a0_uart_tx_if;
    logic [31:0] a0_in;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    modport master (output a0_in, input tx, input busy, input words_sent);
    modport slave  (input a0_in, output tx, output busy, output words_sent);
endinterface

// File: rtl/a0_uart_tx.sv
// a0_uart_tx -- watches register a0 and streams every newly observed value out
// of a UART 8N1 line as four bytes, most-significant byte first, LSB first
// within each byte.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : a0_uart_tx_if.slave (a0_in in; tx, busy, words_sent out)
// A new word is accepted only while idle, so values that come and go during a
// transmission are dropped; only the value present when idle is sent.
module a0_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    a0_uart_tx_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic [15:0] words_sent_q, words_sent_d;

    logic        bit_done_s;
    logic [2:0]  next_bit_s;

    assign bit_done_s = (cnt_q == LAST_CNT);
    assign next_bit_s = bit_idx_q + 3'd1;

    // Next-state, next-output and counter computation for the word transmitter.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        cnt_d        = cnt_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        words_sent_d = words_sent_q;

        case (state_q)
            IDLE: begin
                if (bus.a0_in != shadow_q) begin
                    shadow_d   = bus.a0_in;
                    shift_d    = bus.a0_in;
                    state_d    = START;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    cnt_d      = 16'd0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (bit_done_s) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    // {~byte_idx, bit} == 8*(3-byte_idx)+bit: byte 0 is bits [31:24].
                    tx_d      = shift_q[{~byte_idx_q, 3'd0}];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = next_bit_s;
                        tx_d      = shift_q[{~byte_idx_q, next_bit_s}];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    cnt_d = 16'd0;
                    if (byte_idx_q == 2'd3) begin
                        state_d      = IDLE;
                        tx_d         = 1'b1;
                        busy_d       = 1'b0;
                        words_sent_d = words_sent_q + 16'd1;
                    end else begin
                        // Next byte's start bit follows the stop bit with no gap.
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any pending change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_q     <= 32'd0;
            shift_q      <= 32'd0;
            byte_idx_q   <= 2'd0;
            bit_idx_q    <= 3'd0;
            cnt_q        <= 16'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            words_sent_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.words_sent = words_sent_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// tb_a0_uart_tx -- self-checking bench for a0_uart_tx (CLKS_PER_BIT = 16).
// A word-level reference model (word in flight + cycle offset) predicts tx,
// busy and words_sent after every clock edge; an independent line monitor
// decodes frames mid-bit so directed scenarios can be pinned to literal values.
module tb_a0_uart_tx;

    localparam int CPB      = 16;
    localparam int WORD_CYC = 40 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    a0_uart_tx_if bus ();

    a0_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [31:0] m_word   = 32'd0;
    logic [31:0] m_shadow = 32'd0;
    logic [15:0] m_count  = 16'd0;

    // line monitor state
    int          mon_cnt   = 0;
    int          mon_idle  = 0;
    int          last_gap  = -1;
    int          frame_bad = 0;
    logic [31:0] mon_word  = 32'd0;
    logic [31:0] rxq[$];
    int          lenq[$];

    // Expected line level t cycles into a word: 40 slots of CPB cycles,
    // 10 slots per byte (start, 8 data LSB first, stop), MSB byte first.
    function automatic logic exp_tx(input logic [31:0] w, input int t);
        int byte_n;
        int slot;
        byte_n = t / (10 * CPB);
        slot   = (t % (10 * CPB)) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return w[8 * (3 - byte_n) + slot - 1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model update, per-cycle compare and line monitor, all one cycle at a time.
    initial begin
        logic        r;
        logic [31:0] a;
        logic        etx;
        forever begin
            @(posedge clk);
            r = rst;
            a = bus.a0_in;
            if (r) begin
                m_active = 1'b0; m_t = 0; m_shadow = 32'd0; m_count = 16'd0;
            end else if (m_active) begin
                m_t++;
                if (m_t == WORD_CYC) begin
                    m_active = 1'b0;
                    m_count  = m_count + 16'd1;
                end
            end else if (a !== m_shadow) begin
                m_shadow = a; m_word = a; m_active = 1'b1; m_t = 0;
            end
            #1;
            etx = m_active ? exp_tx(m_word, m_t) : 1'b1;
            check("tx", {31'd0, bus.tx}, {31'd0, etx});
            check("busy", {31'd0, bus.busy}, {31'd0, m_active});
            check("words_sent", {16'd0, bus.words_sent}, {16'd0, m_count});

            if (r) begin
                mon_cnt = 0; mon_idle = 0;
            end else if (bus.busy === 1'b1) begin
                if (mon_cnt == 0) begin
                    last_gap = mon_idle;
                    mon_word = 32'd0;
                end
                mon_idle = 0;
                if ((mon_cnt % CPB) == (CPB / 2)) begin
                    int s, b, k;
                    s = mon_cnt / CPB; b = s / 10; k = s % 10;
                    if (k == 0) begin
                        if (bus.tx !== 1'b0) frame_bad++;
                    end else if (k == 9) begin
                        if (bus.tx !== 1'b1) frame_bad++;
                    end else if (b < 4) begin
                        mon_word[8 * (3 - b) + k - 1] = bus.tx;
                    end else begin
                        frame_bad++;
                    end
                end
                mon_cnt++;
            end else begin
                if (mon_cnt > 0) begin
                    rxq.push_back(mon_word);
                    lenq.push_back(mon_cnt);
                    mon_cnt = 0;
                end
                mon_idle++;
            end
        end
    end

    task automatic wait_busy(input logic v, input int budget, input string name);
        int k;
        k = 0;
        while (bus.busy !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy !== v) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: busy=%b required %b within %0d cycles", name, bus.busy, v, budget);
        end
    endtask

    task automatic do_reset(input logic [31:0] v);
        @(negedge clk);
        rst       = 1'b1;
        bus.a0_in = v;
        @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        lenq.delete();
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rxq.size()) return rxq[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int len_at(input int i);
        if (i < lenq.size()) return lenq[i];
        return -1;
    endfunction

    initial begin
        bus.a0_in = 32'd0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", {31'd0, bus.tx}, 32'd1);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_words", {16'd0, bus.words_sent}, 32'd0);

        // zero after reset must never start a word
        repeat (1000) @(negedge clk);
        check("idle_no_frames", rxq.size(), 32'd0);
        check("idle_words", {16'd0, bus.words_sent}, 32'd0);

        // plain word
        bus.a0_in = 32'h1234_5678;
        wait_busy(1'b1, 10, "w1_start");
        wait_busy(1'b0, WORD_CYC + 10, "w1_end");
        check("w1_frames", rxq.size(), 32'd1);
        check("w1_data", rx_at(0), 32'h1234_5678);
        check("w1_len", len_at(0), 32'd640);
        check("w1_words", {16'd0, bus.words_sent}, 32'd1);

        // changes during flight are dropped except the value seen when idle
        do_reset(32'd0);
        bus.a0_in = 32'hAAAA_5555;
        wait_busy(1'b1, 10, "w2_start");
        repeat (100) @(negedge clk);
        bus.a0_in = 32'h0000_0001;
        repeat (200) @(negedge clk);
        bus.a0_in = 32'h0000_0002;
        wait_busy(1'b0, WORD_CYC, "w2a_end");
        wait_busy(1'b1, 10, "w2b_start");
        wait_busy(1'b0, WORD_CYC + 10, "w2b_end");
        check("w2_frames", rxq.size(), 32'd2);
        check("w2_first", rx_at(0), 32'hAAAA_5555);
        check("w2_second", rx_at(1), 32'h0000_0002);
        check("w2_gap", last_gap, 32'd1);
        check("w2_words", {16'd0, bus.words_sent}, 32'd2);

        // reset mid-frame aborts, then the held value is resent from byte 0
        do_reset(32'd0);
        bus.a0_in = 32'hFFFF_FFFF;
        wait_busy(1'b1, 10, "w3_start");
        repeat (250) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("w3_abort_tx", {31'd0, bus.tx}, 32'd1);
        check("w3_abort_busy", {31'd0, bus.busy}, 32'd0);
        check("w3_abort_words", {16'd0, bus.words_sent}, 32'd0);
        wait_busy(1'b1, 10, "w3_restart");
        wait_busy(1'b0, WORD_CYC + 10, "w3_end");
        check("w3_frames", rxq.size(), 32'd1);
        check("w3_data", rx_at(0), 32'hFFFF_FFFF);
        check("w3_len", len_at(0), 32'd640);
        check("w3_words", {16'd0, bus.words_sent}, 32'd1);

        // counter wrap
        do_reset(32'd0);
        @(negedge clk);
        dut.words_sent_q = 16'hFFFF;
        m_count          = 16'hFFFF;
        bus.a0_in        = 32'h0000_0001;
        wait_busy(1'b1, 10, "w4_start");
        wait_busy(1'b0, WORD_CYC + 10, "w4_end");
        check("w4_wrap", {16'd0, bus.words_sent}, 32'd0);

        // A->B->A inside one transmission yields a single word
        do_reset(32'd0);
        bus.a0_in = 32'h0000_0005;
        wait_busy(1'b1, 10, "w5_start");
        repeat (100) @(negedge clk);
        bus.a0_in = 32'h0000_0006;
        repeat (200) @(negedge clk);
        bus.a0_in = 32'h0000_0005;
        wait_busy(1'b0, WORD_CYC, "w5_end");
        repeat (200) @(negedge clk);
        check("w5_busy", {31'd0, bus.busy}, 32'd0);
        check("w5_frames", rxq.size(), 32'd1);
        check("w5_data", rx_at(0), 32'h0000_0005);
        check("w5_words", {16'd0, bus.words_sent}, 32'd1);

        // randomized traffic: value changes, repeats and occasional resets
        do_reset(32'd0);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bus.a0_in = $urandom;
                    1:       bus.a0_in = m_shadow;
                    default: bus.a0_in = {24'd0, 8'($urandom_range(0, 255))};
                endcase
            end
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;

        check("frame_format", frame_bad, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/a0_uart_tx.md
A0_UART_TX -- requirements
Module: a0_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit period; legal range is 2 to 65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a0_in  input  32  live value of register x10 (a0) from the register file; may change on any cycle.
REQ-005 tx  output  1  UART 8N1 serial line; idle level is 1.
REQ-006 busy  output  1  high while a word transmission is in progress.
REQ-007 words_sent  output  16  count of completed word transmissions.

Function
REQ-008 The block SHALL hold a 32-bit shadow register containing the last value accepted for transmission.
REQ-009 The block SHALL implement the states IDLE, START, DATA and STOP, with a 2-bit byte index, a 3-bit bit index and a bit-period counter.
REQ-010 In IDLE, if a0_in != shadow in cycle N, the block SHALL load shadow and the shift buffer with a0_in at edge N, enter START and set byte index to 0.
REQ-011 tx and busy SHALL be registered: in cycle N+1, tx=0 and busy=1.
REQ-012 Each of START, DATA (per bit) and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by the bit-period counter.
REQ-013 Bytes SHALL be sent most-significant byte first (bits [31:24] down to [7:0]).
REQ-014 Bits within each byte SHALL be sent LSB first.
REQ-015 START -> DATA after one bit period; DATA -> STOP after 8 bits; during STOP, tx=1.
REQ-016 At the end of STOP with byte index < 3: increment byte index and enter START with no idle gap.
REQ-017 At the end of STOP with byte index 3: enter IDLE, increment words_sent (modulo 2^16, wrapping 0xFFFF -> 0x0000) and drive busy=0 in the following cycle.
REQ-018 One word SHALL occupy exactly 40*CLKS_PER_BIT cycles with busy=1.
REQ-019 Changes on a0_in while busy SHALL NOT alter the word in flight.
REQ-020 After returning to IDLE, the block SHALL compare the then-current a0_in against shadow; if they differ, the next word starts on the first IDLE cycle, giving exactly 1 cycle with busy=0 between words.
REQ-021 Intermediate values, including A->B->A sequences fully contained within a transmission, SHALL be dropped; only the value present in IDLE is sent.
REQ-022 If a0_in == shadow in IDLE, the block SHALL stay in IDLE with tx=1 and busy=0.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL set state=IDLE, tx=1, busy=0, words_sent=0, shadow=0, and clear all counters and indices.
REQ-024 Reset asserted mid-transmission SHALL abort the frame immediately: tx=1 in the next cycle, and no partial byte completes.
REQ-025 Reset SHALL take priority over change detection in the same cycle.
REQ-026 After reset, a0_in=0 SHALL NOT trigger a transmission.

Verification (CLKS_PER_BIT=16)
REQ-027 Hold a0_in=0 for 1000 cycles after reset -> tx=1, busy=0, words_sent=0 throughout.
REQ-028 Set a0_in=0x12345678 -> tx shows bytes 0x12, 0x34, 0x56, 0x78 (8N1, LSB first, 16 cycles/bit), busy high for exactly 640 cycles, then words_sent=1.
REQ-029 Set a0_in=0xAAAA5555, then change to 0x00000001 at cycle 100 and to 0x00000002 at cycle 300 of the transmission -> first word is 0xAAAA5555; one busy-low cycle; second word is 0x00000002; words_sent=2.
REQ-030 Assert rst for 1 cycle at cycle 250 of a transmission of 0xFFFFFFFF with a0_in held -> tx=1 the next cycle, words_sent=0; the word restarts from byte 0 on the first IDLE cycle after reset and completes, giving words_sent=1.
REQ-031 Preload 65535 completed words (force or long run) and send one more -> words_sent wraps to 0x0000.
REQ-032 Change a0_in 0x5 -> 0x6 -> 0x5 entirely within one 0x5 transmission -> no second word; busy stays 0 afterwards.
